// File: rtl/seq_det_sched_pkg.sv
// Shared constants and types for the sequence-detector scheduler.
// Contents: detector pattern width and the job FSM state encoding.
// Imported by seq_det_sched and seq_det_rr_arb.
package seq_det_sched_pkg;

  // Width of the external detector's programmable pattern; fixed by the detector.
  localparam int PAT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_det_rr_arb.sv
// Requester arbiter: one-hot grant plus index, pointer advances on accept.
// Ports: clk/resetn, req (request vector), adv (grant accepted), grant (one-hot), grant_idx.
// Macro SEQDET_SCHED_FIXED_PRIO_EN: fixed priority (lowest index wins), no pointer state.
module seq_det_rr_arb
  import seq_det_sched_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  // Index that has highest priority this cycle.
  logic [IW-1:0] base;

`ifdef SEQDET_SCHED_FIXED_PRIO_EN
  assign base = '0;
`else
  logic [IW-1:0] ptr;

  // After a grant to i, i+1 becomes highest priority (wrapping to 0).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign base = ptr;
`endif

  int  cand;
  logic found;

  // Scan requesters starting at base; first active one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(base) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Shares one 5-bit programmable sequence detector among NUM_REQ requesters: grants a job,
// loads its pattern, shifts the DATA_W-bit word MSB-first, counts masked matches, responds.
// Ports: req_* (job in, req_ready accept pulse), det_* (detector), rsp_* (valid/ready result).
// Macro SEQDET_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration instead of round-robin.
module seq_det_sched
  import seq_det_sched_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*PAT_W-1:0]     req_pattern,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [PAT_W-1:0]             det_init,
  output logic                         det_din,
  input  logic                         det_seen,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [$clog2(DATA_W+1)-1:0]  rsp_hits,
  output logic [$clog2(DATA_W)-1:0]    rsp_first_pos
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(DATA_W);

  state_t              state;
  logic [DATA_W-1:0]   data_sr;   // remaining bits, next one at MSB
  logic [PW-1:0]       idx;       // index of bit currently on det_din
  logic [PW-1:0]       chk_idx;   // index whose window det_seen reflects now
  logic                chk_vld;
  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       grant_idx;
  logic                adv;
  logic                hit;
  logic [PAT_W-1:0]    win_pat;
  logic [DATA_W-1:0]   win_dat;

  assign adv     = (state == IDLE) && (|req_valid);
  assign win_pat = req_pattern[grant_idx*PAT_W +: PAT_W];
  assign win_dat = req_data[grant_idx*DATA_W +: DATA_W];

  // Accept pulse is the arbiter decision during the IDLE cycle; the job is latched
  // on the edge that ends it, so the pulse lasts exactly one cycle.
  assign req_ready = (resetn && state == IDLE) ? grant : '0;

  // Windows ending before PAT_W-1 still contain the previous job's bits.
  assign hit = chk_vld && det_seen && (chk_idx >= PW'(PAT_W - 1));

  seq_det_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req_valid),
    .adv       (adv),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      data_sr       <= '0;
      idx           <= '0;
      chk_idx       <= '0;
      chk_vld       <= 1'b0;
      det_init      <= '0;
      det_din       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_hits      <= '0;
      rsp_first_pos <= '0;
    end else begin
      // chk_vld is only set in SHIFT/DRAIN, so hits never collide with the IDLE clear.
      if (hit) begin
        rsp_hits <= rsp_hits + 1'b1;
        if (rsp_hits == '0) rsp_first_pos <= chk_idx;
      end

      case (state)
        IDLE: begin
          if (|req_valid) begin
            det_init      <= win_pat;
            det_din       <= win_dat[DATA_W-1];
            data_sr       <= win_dat << 1;
            rsp_id        <= grant_idx;
            rsp_hits      <= '0;
            rsp_first_pos <= '0;
            idx           <= '0;
            chk_vld       <= 1'b0;
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          chk_vld <= 1'b1;
          chk_idx <= idx;
          if (idx == PW'(DATA_W - 1)) begin
            det_din <= 1'b0;
            state   <= DRAIN;
          end else begin
            idx     <= idx + 1'b1;
            det_din <= data_sr[DATA_W-1];
            data_sr <= data_sr << 1;
          end
        end
        DRAIN: begin
          chk_vld   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
